// File: rtl/btc_pkg.sv
// rtl/btc_pkg.sv - constants, state/phase enums and byte-order helpers for the nonce scheduler
package btc_pkg;

    localparam logic [255:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] PAD_ONE     = 32'h8000_0000;
    localparam logic [31:0] PAD_LEN_HDR = 32'h0000_0280;
    localparam logic [31:0] PAD_LEN_DIG = 32'h0000_0100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MID,
        ST_SECOND,
        ST_FINAL,
        ST_CHECK,
        ST_DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_MID,
        PH_SECOND,
        PH_FINAL
    } phase_t;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [255:0] byte_rev256(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = x[255-8*i -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_stream.sv
// rtl/sha256_stream.sv - one SHA-256 compression; pulls 16 message words over a rq/rdy word bus
module sha256_stream (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] state_in,
    output logic         rq,
    output logic [3:0]   addr,
    input  logic [31:0]  data,
    input  logic         rdy,
    output logic         done,
    output logic [255:0] state_out
);

    typedef enum logic [1:0] {C_IDLE, C_LOAD, C_RUN, C_FIN} core_state_t;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    core_state_t  cst;
    logic [6:0]   cnt;
    logic [31:0]  va, vb, vc, vd, ve, vf, vg, vh;
    logic [255:0] hin;
    logic [31:0]  win [16];
    logic [31:0]  wt, t1, t2;

    assign addr = cnt[3:0];

    // Rounds 0..15 consume the bus word directly; later rounds expand from the 16-word window
    always_comb begin
        if (cst == C_LOAD) begin
            wt = data;
        end else begin
            wt = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
        end
        t1 = vh + bsig1(ve) + ((ve & vf) ^ (~ve & vg)) + K[cnt[5:0]] + wt;
        t2 = bsig0(va) + ((va & vb) ^ (va & vc) ^ (vb & vc));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cst       <= C_IDLE;
            cnt       <= 7'd0;
            rq        <= 1'b0;
            done      <= 1'b0;
            {va, vb, vc, vd, ve, vf, vg, vh} <= 256'd0;
            hin       <= 256'd0;
            state_out <= 256'd0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'd0;
            end
        end else begin
            done <= 1'b0;
            if (start) begin
                cst <= C_LOAD;
                cnt <= 7'd0;
                rq  <= 1'b1;
                hin <= state_in;
                {va, vb, vc, vd, ve, vf, vg, vh} <= state_in;
            end else begin
                case (cst)
                    C_LOAD, C_RUN: begin
                        if (cst == C_RUN || (rq && rdy)) begin
                            {va, vb, vc, vd, ve, vf, vg, vh} <=
                                {t1 + t2, va, vb, vc, vd + t1, ve, vf, vg};
                            for (int i = 0; i < 15; i++) begin
                                win[i] <= win[i+1];
                            end
                            win[15] <= wt;
                            cnt     <= cnt + 7'd1;
                            rq      <= 1'b0;
                            if (cnt == 7'd15) begin
                                cst <= C_RUN;
                            end
                            if (cnt == 7'd63) begin
                                cst <= C_FIN;
                            end
                        end else begin
                            rq <= 1'b1;
                        end
                    end
                    C_FIN: begin
                        state_out <= {hin[255:224] + va, hin[223:192] + vb,
                                      hin[191:160] + vc, hin[159:128] + vd,
                                      hin[127:96]  + ve, hin[95:64]   + vf,
                                      hin[63:32]   + vg, hin[31:0]    + vh};
                        done <= 1'b1;
                        cst  <= C_IDLE;
                    end
                    default: cst <= C_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/btc_nonce_sched.sv
// rtl/btc_nonce_sched.sv - double-SHA-256 nonce range scanner driving one sha256_stream core
// Build option: BTC_MIDSTATE_CACHE_EN keeps the first-block midstate across nonces
module btc_nonce_sched
    import btc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hdr_we,
    input  logic [4:0]   hdr_addr,
    input  logic [31:0]  hdr_wdata,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         start,
    input  logic         abort,
    output logic         busy,
    output logic         job_done,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [255:0] hash_out
);

    sched_state_t state;
    phase_t       phase;

    logic         core_start;
    logic [255:0] core_state_in;
    logic         core_rq;
    logic         core_rdy;
    logic [3:0]   core_addr;
    logic [31:0]  core_data;
    logic         core_done;
    logic [255:0] core_state_out;

    logic [31:0]  hdr [20];
    logic [31:0]  nonce;
    logic [31:0]  nonce_last;
    logic [255:0] target_q;
    logic         abort_pend;
    logic         abort_now;
    logic         hit;
`ifdef BTC_MIDSTATE_CACHE_EN
    logic [255:0] midstate;
`endif

    sha256_stream u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (core_start),
        .state_in  (core_state_in),
        .rq        (core_rq),
        .addr      (core_addr),
        .data      (core_data),
        .rdy       (core_rdy),
        .done      (core_done),
        .state_out (core_state_out)
    );

    // No registered stage on the word bus: every request is answered in the same cycle
    assign core_rdy  = core_rq;
    assign abort_now = abort_pend | abort;
    assign hit       = (byte_rev256(core_state_out) <= target_q);

    always_comb begin
        case (state)
            ST_MID:    phase = PH_MID;
            ST_SECOND: phase = PH_SECOND;
            ST_FINAL:  phase = PH_FINAL;
            default:   phase = PH_NONE;
        endcase
    end

    always_comb begin
        core_state_in = SHA256_IV;
        if (phase == PH_SECOND) begin
`ifdef BTC_MIDSTATE_CACHE_EN
            core_state_in = midstate;
`else
            core_state_in = core_state_out;
`endif
        end
    end

    // FINAL reads the SECOND digest straight from the core, which holds it until FINAL completes
    always_comb begin
        core_data = 32'd0;
        case (phase)
            PH_MID: core_data = hdr[{1'b0, core_addr}];
            PH_SECOND: begin
                case (core_addr)
                    4'd0, 4'd1, 4'd2: core_data = hdr[5'd16 + {3'b000, core_addr[1:0]}];
                    4'd3:             core_data = bswap32(nonce);
                    4'd4:             core_data = PAD_ONE;
                    4'd15:            core_data = PAD_LEN_HDR;
                    default:          core_data = 32'd0;
                endcase
            end
            PH_FINAL: begin
                if (!core_addr[3]) begin
                    core_data = core_state_out[{3'd7 - core_addr[2:0], 5'd0} +: 32];
                end else if (core_addr == 4'd8) begin
                    core_data = PAD_ONE;
                end else if (core_addr == 4'd15) begin
                    core_data = PAD_LEN_DIG;
                end
            end
            default: core_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hdr_we && !busy && hdr_addr < 5'd20) begin
            hdr[hdr_addr] <= hdr_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            core_start  <= 1'b0;
            busy        <= 1'b0;
            job_done    <= 1'b0;
            found       <= 1'b0;
            found_nonce <= 32'd0;
            hash_out    <= 256'd0;
            nonce       <= 32'd0;
            nonce_last  <= 32'd0;
            target_q    <= 256'd0;
            abort_pend  <= 1'b0;
`ifdef BTC_MIDSTATE_CACHE_EN
            midstate    <= 256'd0;
`endif
        end else begin
            core_start <= 1'b0;
            job_done   <= 1'b0;
            if (busy && abort) begin
                abort_pend <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_MID;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        found      <= 1'b0;
                        nonce      <= nonce_start;
                        nonce_last <= nonce_end;
                        target_q   <= target;
                        abort_pend <= 1'b0;
                    end
                end
                ST_MID: begin
                    if (core_done) begin
                        if (abort_now) begin
                            state    <= ST_DONE;
                            job_done <= 1'b1;
                        end else begin
                            state      <= ST_SECOND;
                            core_start <= 1'b1;
`ifdef BTC_MIDSTATE_CACHE_EN
                            midstate   <= core_state_out;
`endif
                        end
                    end
                end
                ST_SECOND: begin
                    if (core_done) begin
                        if (abort_now) begin
                            state    <= ST_DONE;
                            job_done <= 1'b1;
                        end else begin
                            state      <= ST_FINAL;
                            core_start <= 1'b1;
                        end
                    end
                end
                ST_FINAL: begin
                    if (core_done) begin
                        if (abort_now) begin
                            state    <= ST_DONE;
                            job_done <= 1'b1;
                        end else begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    hash_out <= core_state_out;
                    if (hit) begin
                        found       <= 1'b1;
                        found_nonce <= nonce;
                        state       <= ST_DONE;
                        job_done    <= 1'b1;
                    end else if (nonce == nonce_last) begin
                        state    <= ST_DONE;
                        job_done <= 1'b1;
                    end else begin
                        nonce      <= nonce + 32'd1;
                        core_start <= 1'b1;
`ifdef BTC_MIDSTATE_CACHE_EN
                        state      <= ST_SECOND;
`else
                        state      <= ST_MID;
`endif
                    end
                end
                ST_DONE: begin
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btc_nonce_sched.sv
// tb/tb_btc_nonce_sched.sv - scoreboard bench for btc_nonce_sched on the genesis block header
module tb_btc_nonce_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         hdr_we;
    logic [4:0]   hdr_addr;
    logic [31:0]  hdr_wdata;
    logic [255:0] target;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic         start;
    logic         abort;
    logic         busy;
    logic         job_done;
    logic         found;
    logic [31:0]  found_nonce;
    logic [255:0] hash_out;

    btc_nonce_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hdr_we      (hdr_we),
        .hdr_addr    (hdr_addr),
        .hdr_wdata   (hdr_wdata),
        .target      (target),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .job_done    (job_done),
        .found       (found),
        .found_nonce (found_nonce),
        .hash_out    (hash_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         found;
        logic [31:0]  nonce;
        logic         chk_hash;
        logic [255:0] hash_rev;
        int           starts;
    } exp_t;

    localparam logic [255:0] GEN_REV =
        256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] ALL_ONES = {256{1'b1}};
    localparam logic [255:0] TGT_DIFF1 = {64'h00000000_FFFF0000, 192'd0};

    exp_t        sb[$];
    logic [31:0] gen_hdr [20];
    int          checks = 0;
    int          passes = 0;
    int          fails = 0;
    int          n_starts = 0;
    int          base = 0;

    always @(negedge clk) begin
        if (rst_n && dut.core_start) n_starts++;
    end

    function automatic logic [255:0] rev(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
        return r;
    endfunction

    function automatic int exp_starts(input int n);
`ifdef BTC_MIDSTATE_CACHE_EN
        return 1 + 2 * n;
`else
        return 3 * n;
`endif
    endfunction

    function automatic exp_t mk(input logic f, input logic [31:0] n, input logic ch,
                                input logic [255:0] h, input int s);
        exp_t e;
        e.found = f; e.nonce = n; e.chk_hash = ch; e.hash_rev = h; e.starts = s;
        return e;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic load_header();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hdr_we = 1'b1; hdr_addr = i[4:0]; hdr_wdata = gen_hdr[i];
        end
        @(negedge clk);
        hdr_we = 1'b0;
    endtask

    task automatic kick(input logic [255:0] t, input logic [31:0] ns, input logic [31:0] ne);
        @(negedge clk);
        target = t; nonce_start = ns; nonce_end = ne; start = 1'b1;
        base = n_starts;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", busy, 1);
    endtask

    task automatic wait_job(input string tag, input int budget);
        exp_t e;
        bit   seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (job_done === 1'b1) begin seen = 1; break; end
        end
        check({tag, "_job_done"}, seen, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (!seen) return;
        check({tag, "_found"}, found, e.found);
        if (e.found) check({tag, "_found_nonce"}, found_nonce, e.nonce);
        if (e.chk_hash) check({tag, "_hash"}, rev(hash_out), e.hash_rev);
        check({tag, "_core_starts"}, n_starts - base, e.starts);
        @(negedge clk);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_found_held"}, found, e.found);
    endtask

    initial begin
        bit seen;
        gen_hdr = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
                    32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a,
                    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
        rst_n = 1'b0; hdr_we = 1'b0; hdr_addr = 5'd0; hdr_wdata = 32'd0;
        target = 256'd0; nonce_start = 32'd0; nonce_end = 32'd0; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_job_done", job_done, 0);
        check("rst_found", found, 0);
        check("rst_found_nonce", found_nonce, 0);
        check("rst_hash_out", hash_out, 0);
        check("rst_core_start", dut.core_start, 0);
        rst_n = 1'b1;
        load_header();

        // abort in IDLE is ignored and start wins
        sb.push_back(mk(1'b1, 32'h7C2BAC1D, 1'b1, GEN_REV, exp_starts(1)));
        abort = 1'b1;
        kick(ALL_ONES, 32'h7C2BAC1D, 32'h7C2BAC1D);
        abort = 1'b0;
        wait_job("genesis", 3000);

        sb.push_back(mk(1'b1, 32'h7C2BAC1D, 1'b1, GEN_REV, exp_starts(4)));
        kick(TGT_DIFF1, 32'h7C2BAC1A, 32'h7C2BAC20);
        wait_job("scan7", 6000);
        repeat (300) @(negedge clk);
        check("scan7_no_more_starts", n_starts - base, exp_starts(4));

        sb.push_back(mk(1'b0, 32'h0, 1'b0, 256'd0, exp_starts(3)));
        kick(256'd0, 32'hFFFFFFFF, 32'h00000001);
        wait_job("wrap", 5000);

        sb.push_back(mk(1'b0, 32'h0, 1'b0, 256'd0, exp_starts(2)));
        kick(256'd0, 32'h7C2BAC1A, 32'h7C2BAC20);
        for (int i = 0; i < 3000 && (n_starts - base) < exp_starts(2); i++) @(negedge clk);
        check("abort_reach_final", n_starts - base, exp_starts(2));
        repeat (10) @(negedge clk);
        abort = 1'b1; start = 1'b1; hdr_we = 1'b1; hdr_addr = 5'd0; hdr_wdata = 32'hdeadbeef;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; hdr_we = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dut.core_done === 1'b1) begin seen = 1; break; end
        end
        check("abort_final_done", seen, 1);
        wait_job("abort", 1);

        sb.push_back(mk(1'b1, 32'h7C2BAC1D, 1'b1, GEN_REV, exp_starts(1)));
        kick(ALL_ONES, 32'h7C2BAC1D, 32'h7C2BAC1D);
        wait_job("hdr_kept", 3000);

        kick(ALL_ONES, 32'h7C2BAC1D, 32'h7C2BAC1D);
        for (int i = 0; i < 3000 && (n_starts - base) < 2; i++) @(negedge clk);
        check("reset_reach_second", n_starts - base, 2);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_job_done", job_done, 0);
        check("midrst_found", found, 0);
        check("midrst_found_nonce", found_nonce, 0);
        check("midrst_hash_out", hash_out, 0);
        rst_n = 1'b1;
        load_header();
        sb.push_back(mk(1'b1, 32'h7C2BAC1D, 1'b1, GEN_REV, exp_starts(1)));
        kick(ALL_ONES, 32'h7C2BAC1D, 32'h7C2BAC1D);
        wait_job("after_reset", 3000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
